// File: rtl/pc_sequencer.sv
// Purpose : two-stage fetch/decode PC sequencer with branch/jump redirect and wrong-path squash.
// Latency : a redirect seen in decode lands on pc at the next unstalled edge (one cycle).
// Backpressure: stall high freezes pc, decodePc, FSM state and flush; nothing is dropped.
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics (no squash after redirect).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] branchOffset,
    input  logic [25:0] jumpTarget,
    output logic [31:0] pc,
    output logic [31:0] decodePc,
    output logic        decodeValid,
    output logic        flush
);

    // START: nothing fetched into decode yet. RUN: decode is live.
    // FLUSH: decode holds the squashed fall-through instruction.
    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic        flush_nxt;

    logic [31:0] slot_pc;      // address following the decode instruction
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] pc_nxt;
    logic        taken;
    logic        redirect;

    // Decode is live only in RUN; reset forces it low without waiting for a clock.
    assign decodeValid = (state == RUN) && !reset;

    // Redirect decision and next fetch address. Jump outranks any branch; code 11 is a no-op.
    always_comb begin
        slot_pc    = decodePc + 32'd4;
        branch_tgt = slot_pc + (branchOffset << 2);
        jump_tgt   = {slot_pc[31:28], jumpTarget, 2'b00};
        taken      = decodeValid && (((branch == BR_BEQ) && zero) ||
                                     ((branch == BR_BNE) && !zero));
        redirect   = decodeValid && (jump || taken);
        pc_nxt     = pc + 32'd4;
        if (redirect) begin
            pc_nxt = jump ? jump_tgt : branch_tgt;
        end
    end

    // Next-state logic; flush is the registered image of entering FLUSH.
    always_comb begin
        state_nxt = state;
        flush_nxt = 1'b0;
        case (state)
            START: begin
                state_nxt = RUN;
            end
            RUN: begin
`ifdef BRANCH_DELAY_SLOT_EN
                // The instruction after a branch/jump is the delay slot and always executes.
                state_nxt = RUN;
`else
                if (redirect) begin
                    state_nxt = FLUSH;
                    flush_nxt = 1'b1;
                end
`endif
            end
            FLUSH: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = START;
            end
        endcase
    end

    // Sequencer state register; a stall holds everything, so a pending redirect simply waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            decodePc <= 32'd0;
            state    <= START;
            flush    <= 1'b0;
        end else if (!stall) begin
            pc       <= pc_nxt;
            decodePc <= pc;
            state    <= state_nxt;
            flush    <= flush_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  branch;
    logic        jump;
    logic        zero;
    logic [31:0] branchOffset;
    logic [25:0] jumpTarget;
    logic [31:0] pc;
    logic [31:0] decodePc;
    logic        decodeValid;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch       (branch),
        .jump         (jump),
        .zero         (zero),
        .branchOffset (branchOffset),
        .jumpTarget   (jumpTarget),
        .pc           (pc),
        .decodePc     (decodePc),
        .decodeValid  (decodeValid),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks the fetch address, the decode address, whether anything has reached decode
    // since reset, and whether the decode slot holds a squashed wrong-path instruction.
    logic [31:0] m_pc;
    logic [31:0] m_dpc;
    bit          m_started;
    bit          m_squash;

    function automatic void model_reset();
        m_pc      = RST_PC;
        m_dpc     = 32'd0;
        m_started = 1'b0;
        m_squash  = 1'b0;
    endfunction

    function automatic void model_step(input logic s, input logic [1:0] b, input logic j,
                                       input logic z, input logic [31:0] o, input logic [25:0] t);
        bit          live;
        bit          tk;
        bit          redir;
        logic [31:0] seq;
        logic [31:0] tgt;
        if (s) return;
        live  = m_started && !m_squash;
        tk    = live && ((b == 2'd1 && z) || (b == 2'd2 && !z));
        redir = live && (j || tk);
        seq   = m_dpc + 32'd4;
        if (redir && j)  tgt = {seq[31:28], t, 2'b00};
        else if (redir)  tgt = seq + o * 32'd4;
        else             tgt = m_pc + 32'd4;
        m_dpc     = m_pc;
        m_pc      = tgt;
        m_started = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        m_squash  = 1'b0;
`else
        m_squash  = redir;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_dpc,
                           input logic e_dv, input logic e_fl);
        chk({tag, " pc"},          pc,          e_pc);
        chk({tag, " decodePc"},    decodePc,    e_dpc);
        chk({tag, " decodeValid"}, {31'd0, decodeValid}, {31'd0, e_dv});
        chk({tag, " flush"},       {31'd0, flush},       {31'd0, e_fl});
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input logic s, input logic [1:0] b, input logic j, input logic z,
                         input logic [31:0] o, input logic [25:0] t);
        stall = s; branch = b; jump = j; zero = z; branchOffset = o; jumpTarget = t;
        @(posedge clk);
        model_step(s, b, j, z, o, t);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        chk_all({tag, " in reset"}, RST_PC, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all({tag, " released"}, RST_PC, 32'd0, 1'b0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        s;
        logic [1:0]  b;
        logic        j;
        logic        z;
        logic [31:0] o;
        logic [25:0] t;
        logic [31:0] e_pc;
        logic [31:0] e_dpc;
        logic        e_dv;
        logic        e_fl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic [1:0] b, input logic j, input logic z,
                                input logic [31:0] o, input logic [25:0] t,
                                input logic [31:0] e_pc, input logic [31:0] e_dpc,
                                input logic e_dv, input logic e_fl);
        vec_t v;
        v.s = s; v.b = b; v.j = j; v.z = z; v.o = o; v.t = t;
        v.e_pc = e_pc; v.e_dpc = e_dpc; v.e_dv = e_dv; v.e_fl = e_fl;
        return v;
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; branch = 2'b00; jump = 1'b0; zero = 1'b0;
        branchOffset = 32'd0; jumpTarget = 26'd0;

`ifdef BRANCH_DELAY_SLOT_EN
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0040_0004, 32'h0040_0000, 1, 0));
        tbl.push_back(mk(0, 2'd0, 1, 0, 32'd0, 26'h80,  32'h0000_0200, 32'h0040_0004, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0000_0204, 32'h0000_0200, 1, 0));
        tbl.push_back(mk(0, 2'd1, 0, 1, 32'd4, 26'd0,   32'h0000_0214, 32'h0000_0204, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0000_0218, 32'h0000_0214, 1, 0));
`else
        // start-up from RESET_PC
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0040_0004, 32'h0040_0000, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0040_0008, 32'h0040_0004, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0040_000C, 32'h0040_0008, 1, 0));
        // jump to 0x100, controls in FLUSH ignored
        tbl.push_back(mk(0, 2'd0, 1, 0, 32'd0, 26'h40,  32'h0000_0100, 32'h0040_000C, 0, 1));
        tbl.push_back(mk(0, 2'd1, 0, 1, 32'd7, 26'd0,   32'h0000_0104, 32'h0000_0100, 1, 0));
        // beq taken backwards from 0x100
        tbl.push_back(mk(0, 2'd1, 0, 1, 32'hFFFF_FFFE, 26'd0, 32'h0000_00FC, 32'h0000_0104, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0000_0100, 32'h0000_00FC, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0000_0104, 32'h0000_0100, 1, 0));
        // beq not taken, reserved code, bne taken
        tbl.push_back(mk(0, 2'd1, 0, 0, 32'hFFFF_FFFE, 26'd0, 32'h0000_0108, 32'h0000_0104, 1, 0));
        tbl.push_back(mk(0, 2'd3, 0, 1, 32'd5, 26'd0,   32'h0000_010C, 32'h0000_0108, 1, 0));
        tbl.push_back(mk(0, 2'd2, 0, 0, 32'h10, 26'd0,  32'h0000_014C, 32'h0000_010C, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0000_0150, 32'h0000_014C, 1, 0));
        // long branch into 0x1000_0010, then jump beats bne
        tbl.push_back(mk(0, 2'd1, 0, 1, 32'h03FF_FFB0, 26'd0, 32'h1000_0010, 32'h0000_0150, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h1000_0014, 32'h1000_0010, 1, 0));
        tbl.push_back(mk(0, 2'd2, 1, 0, 32'd9, 26'h40,  32'h1000_0100, 32'h1000_0014, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h1000_0104, 32'h1000_0100, 1, 0));
        // branch with wraparound arithmetic, then pc wraps past FFFF_FFFC
        tbl.push_back(mk(0, 2'd1, 0, 1, 32'h3BFF_FFBD, 26'd0, 32'hFFFF_FFF8, 32'h1000_0104, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'hFFFF_FFFC, 32'hFFFF_FFF8, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h0000_0000, 32'hFFFF_FFFC, 1, 0));
        // jump region taken from the wrapped decodePc+4
        tbl.push_back(mk(0, 2'd0, 1, 0, 32'd0, 26'h3FF_FFFF, 32'h0FFF_FFFC, 32'h0000_0000, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h1000_0000, 32'h0FFF_FFFC, 1, 0));
        // stall over a pending taken beq, then release
        tbl.push_back(mk(1, 2'd1, 0, 1, 32'd3, 26'd0,   32'h1000_0000, 32'h0FFF_FFFC, 1, 0));
        tbl.push_back(mk(1, 2'd1, 0, 1, 32'd3, 26'd0,   32'h1000_0000, 32'h0FFF_FFFC, 1, 0));
        tbl.push_back(mk(1, 2'd1, 0, 1, 32'd3, 26'd0,   32'h1000_0000, 32'h0FFF_FFFC, 1, 0));
        tbl.push_back(mk(0, 2'd1, 0, 1, 32'd3, 26'd0,   32'h1000_000C, 32'h1000_0000, 0, 1));
        // stall during FLUSH holds the squash
        tbl.push_back(mk(1, 2'd0, 0, 0, 32'd0, 26'd0,   32'h1000_000C, 32'h1000_0000, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 0, 32'd0, 26'd0,   32'h1000_0010, 32'h1000_000C, 1, 0));
        tbl.push_back(mk(0, 2'd2, 0, 1, 32'd8, 26'd0,   32'h1000_0014, 32'h1000_0010, 1, 0));
`endif

        @(negedge clk);
        do_reset("init");
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].z, tbl[i].o, tbl[i].t);
            chk_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_dpc, tbl[i].e_dv, tbl[i].e_fl);
        end

`ifndef BRANCH_DELAY_SLOT_EN
        // Redirect into FLUSH, then an asynchronous reset pulse in the middle of the cycle.
        apply(0, 2'd0, 1, 0, 32'd0, 26'h10);
        chk_all("pre-reset flush", 32'h1000_0040, 32'h1000_0014, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all("async reset mid-flush", RST_PC, 32'd0, 1'b0, 1'b0);
        // Controls asserted across release must not redirect the first fetch.
        branch = 2'd1; zero = 1'b1; jump = 1'b1; jumpTarget = 26'h123;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("release with controls", RST_PC, 32'd0, 1'b0, 1'b0);
        apply(0, 2'd1, 1, 1, 32'd4, 26'h123);
        chk_all("first fetch after reset", RST_PC + 32'd4, RST_PC, 1'b1, 1'b0);
`endif

        // Randomized run against the model, with occasional reset pulses.
        do_reset("rand");
        for (int c = 0; c < 3000; c++) begin
            logic        rs;
            logic [1:0]  rb;
            logic        rj;
            logic        rz;
            logic [31:0] ro;
            logic [25:0] rt;
            if ($urandom_range(0, 199) == 0) begin
                do_reset($sformatf("rand%0d", c));
            end
            rs = ($urandom_range(0, 4) == 0);
            rb = 2'($urandom_range(0, 3));
            rj = ($urandom_range(0, 5) == 0);
            rz = 1'($urandom_range(0, 1));
            ro = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32);
            rt = 26'($urandom);
            apply(rs, rb, rj, rz, ro, rt);
            chk_all($sformatf("rand%0d", c), m_pc, m_dpc, m_started && !m_squash, m_squash);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus process ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
